// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: FSM encoding, default widths
// and the tag value written into MEM/WB when a bubble is inserted.
package mem_stage_pkg;

    localparam int DW_DEF      = 32;
    localparam int RW_DEF      = 5;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    localparam logic [3:0] INS_BUBBLE = 4'h0;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. Loads every cycle; a bubble request replaces the
// incoming instruction with an all-zero no-op so write-back does nothing.
module mem_wb_reg
    import mem_stage_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          bubble_i,
    input  logic          load_done_i,
    input  logic          wreg_i,
    input  logic          m2reg_i,
    input  logic [DW-1:0] rdata_i,
    input  logic [DW-1:0] alu_i,
    input  logic [RW-1:0] rn_i,
    input  logic [3:0]    ins_type_i,
    input  logic [3:0]    ins_number_i,
    output logic          wwreg_o,
    output logic          wm2reg_o,
    output logic [DW-1:0] wmo_o,
    output logic [DW-1:0] walu_o,
    output logic [RW-1:0] wrn_o,
    output logic [3:0]    ins_type_o,
    output logic [3:0]    ins_number_o
);

    logic          wwreg_q,      wwreg_d;
    logic          wm2reg_q,     wm2reg_d;
    logic [DW-1:0] wmo_q,        wmo_d;
    logic [DW-1:0] walu_q,       walu_d;
    logic [RW-1:0] wrn_q,        wrn_d;
    logic [3:0]    ins_type_q,   ins_type_d;
    logic [3:0]    ins_number_q, ins_number_d;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would otherwise infer a latch.
        wwreg_d      = 1'b0;
        wm2reg_d     = 1'b0;
        wmo_d        = '0;
        walu_d       = '0;
        wrn_d        = '0;
        ins_type_d   = INS_BUBBLE;
        ins_number_d = INS_BUBBLE;
        if (!bubble_i) begin
            wwreg_d      = wreg_i;
            wm2reg_d     = m2reg_i;
            wmo_d        = load_done_i ? rdata_i : '0;
            walu_d       = alu_i;
            wrn_d        = rn_i;
            ins_type_d   = ins_type_i;
            ins_number_d = ins_number_i;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge values; blocking would chain registers within one edge.
        if (!rst_n) begin
            wwreg_q      <= 1'b0;
            wm2reg_q     <= 1'b0;
            wmo_q        <= '0;
            walu_q       <= '0;
            wrn_q        <= '0;
            ins_type_q   <= INS_BUBBLE;
            ins_number_q <= INS_BUBBLE;
        end else begin
            wwreg_q      <= wwreg_d;
            wm2reg_q     <= wm2reg_d;
            wmo_q        <= wmo_d;
            walu_q       <= walu_d;
            wrn_q        <= wrn_d;
            ins_type_q   <= ins_type_d;
            ins_number_q <= ins_number_d;
        end
    end

    assign wwreg_o      = wwreg_q;
    assign wm2reg_o     = wm2reg_q;
    assign wmo_o        = wmo_q;
    assign walu_o       = walu_q;
    assign wrn_o        = wrn_q;
    assign ins_type_o   = ins_type_q;
    assign ins_number_o = ins_number_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: drives a req/ack data-memory port with a timeout,
// stalls the upstream pipeline while an access is pending, resolves branches.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int RW      = RW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mwreg,
    input  logic          mm2reg,
    input  logic          mwmem,
    input  logic [DW-1:0] maluout,
    input  logic [DW-1:0] mdata_b,
    input  logic [RW-1:0] mrdrt,
    input  logic          mbranch,
    input  logic          mzero,
    input  logic [DW-1:0] mpc,
    input  logic [3:0]    MEM_ins_type,
    input  logic [3:0]    MEM_ins_number,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          dmem_ack,
    output logic          mem_stall,
    output logic          pcsrc,
    output logic [DW-1:0] branch_pc,
    output logic          mem_err,
    output logic          wwreg,
    output logic          wm2reg,
    output logic [DW-1:0] wmo,
    output logic [DW-1:0] walu,
    output logic [RW-1:0] wrn,
    output logic [3:0]    WB_ins_type,
    output logic [3:0]    WB_ins_number
);

    localparam int CW = $clog2(TIMEOUT + 1);
    // The IDLE request cycle is the first of the TIMEOUT budget, so WAIT ends
    // when the count of earlier WAIT cycles reaches TIMEOUT-2.
    localparam logic [CW-1:0] LAST_CNT     = (TIMEOUT >= 2) ? CW'(TIMEOUT - 2) : '0;
    localparam logic          IDLE_ABANDON = (TIMEOUT <= 1);

    mem_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          err_q,   err_d;

    logic access;
    logic req;
    logic complete;
    logic abandon;
    logic timeout_hit;
    logic stall;

    assign access      = mm2reg | mwmem;
    assign req         = rst_n & (access | (state_q == MEM_WAIT));
    assign complete    = req & dmem_ack;
    assign timeout_hit = (state_q == MEM_WAIT) ? (cnt_q >= LAST_CNT) : IDLE_ABANDON;
    assign abandon     = req & ~dmem_ack & timeout_hit;
    assign stall       = req & ~complete & ~abandon;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q | abandon;
        case (state_q)
            MEM_IDLE: begin
                if (stall) begin
                    state_d = MEM_WAIT;
                    cnt_d   = '0;
                end
            end
            MEM_WAIT: begin
                if (complete || abandon) begin
                    state_d = MEM_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_comb begin
        dmem_req  = req;
        dmem_we   = req & mwmem;
        mem_stall = stall;
        pcsrc     = rst_n & mbranch & mzero & ~stall;
        mem_err   = err_q;
    end

    assign dmem_addr  = maluout;
    assign dmem_wdata = mdata_b;
    assign branch_pc  = mpc;

    mem_wb_reg #(
        .DW (DW),
        .RW (RW)
    ) u_mem_wb_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .bubble_i     (stall | abandon),
        .load_done_i  (complete & mm2reg),
        .wreg_i       (mwreg),
        .m2reg_i      (mm2reg),
        .rdata_i      (dmem_rdata),
        .alu_i        (maluout),
        .rn_i         (mrdrt),
        .ins_type_i   (MEM_ins_type),
        .ins_number_i (MEM_ins_number),
        .wwreg_o      (wwreg),
        .wm2reg_o     (wm2reg),
        .wmo_o        (wmo),
        .walu_o       (walu),
        .wrn_o        (wrn),
        .ins_type_o   (WB_ins_type),
        .ins_number_o (WB_ins_number)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vectors with literal expectations
// plus a cycle-by-cycle comparison against a request-age behavioural model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int DW      = 32;
    localparam int RW      = 5;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mwreg = 1'b0, mm2reg = 1'b0, mwmem = 1'b0;
    logic [DW-1:0] maluout = '0, mdata_b = '0, mpc = '0;
    logic [RW-1:0] mrdrt = '0;
    logic          mbranch = 1'b0, mzero = 1'b0;
    logic [3:0]    MEM_ins_type = '0, MEM_ins_number = '0;
    logic          dmem_req, dmem_we;
    logic [DW-1:0] dmem_addr, dmem_wdata;
    logic [DW-1:0] dmem_rdata = '0;
    logic          dmem_ack = 1'b0;
    logic          mem_stall, pcsrc, mem_err;
    logic [DW-1:0] branch_pc;
    logic          wwreg, wm2reg;
    logic [DW-1:0] wmo, walu;
    logic [RW-1:0] wrn;
    logic [3:0]    WB_ins_type, WB_ins_number;

    mem_stage #(.DW(DW), .RW(RW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
        .maluout(maluout), .mdata_b(mdata_b), .mrdrt(mrdrt),
        .mbranch(mbranch), .mzero(mzero), .mpc(mpc),
        .MEM_ins_type(MEM_ins_type), .MEM_ins_number(MEM_ins_number),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .mem_stall(mem_stall), .pcsrc(pcsrc), .branch_pc(branch_pc),
        .mem_err(mem_err),
        .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo), .walu(walu), .wrn(wrn),
        .WB_ins_type(WB_ins_type), .WB_ins_number(WB_ins_number)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an access may request for at most TIMEOUT cycles; age counts the
    // cycles it has already spent requesting without an answer.
    int            age = 0;
    logic          e_req, e_cpl, e_abn, e_stall, e_pcsrc;
    logic          e_err = 1'b0;
    logic          e_wwreg = 1'b0, e_wm2reg = 1'b0;
    logic [DW-1:0] e_wmo = '0, e_walu = '0;
    logic [RW-1:0] e_wrn = '0;
    logic [3:0]    e_type = '0, e_num = '0;

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            e_req   = rst_n & (mm2reg | mwmem);
            e_cpl   = e_req & dmem_ack;
            e_abn   = e_req & ~dmem_ack & (age == TIMEOUT - 1);
            e_stall = e_req & ~e_cpl & ~e_abn;
            e_pcsrc = rst_n & mbranch & mzero & ~e_stall;

            check("dmem_req",   32'(dmem_req),  32'(e_req));
            check("dmem_we",    32'(dmem_we),   32'(e_req & mwmem));
            check("dmem_addr",  dmem_addr,      maluout);
            check("dmem_wdata", dmem_wdata,     mdata_b);
            check("mem_stall",  32'(mem_stall), 32'(e_stall));
            check("pcsrc",      32'(pcsrc),     32'(e_pcsrc));
            check("branch_pc",  branch_pc,      mpc);
            check("mem_err",    32'(mem_err),   32'(e_err));
            check("wwreg",      32'(wwreg),     32'(e_wwreg));
            check("wm2reg",     32'(wm2reg),    32'(e_wm2reg));
            check("wmo",        wmo,            e_wmo);
            check("walu",       walu,           e_walu);
            check("wrn",        32'(wrn),       32'(e_wrn));
            check("wb_type",    32'(WB_ins_type),   32'(e_type));
            check("wb_number",  32'(WB_ins_number), 32'(e_num));

            if (!rst_n || e_stall || e_abn) begin
                e_wwreg = 0; e_wm2reg = 0; e_wmo = '0; e_walu = '0; e_wrn = '0;
                e_type = INS_BUBBLE; e_num = INS_BUBBLE;
            end else begin
                e_wwreg = mwreg; e_wm2reg = mm2reg; e_walu = maluout; e_wrn = mrdrt;
                e_type = MEM_ins_type; e_num = MEM_ins_number;
                e_wmo = (e_cpl && mm2reg) ? dmem_rdata : '0;
            end
            e_err = rst_n & (e_err | e_abn);
            age   = e_stall ? age + 1 : 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        mwreg = 0; mm2reg = 0; mwmem = 0; maluout = '0; mdata_b = '0; mrdrt = '0;
        mbranch = 0; mzero = 0; mpc = '0; MEM_ins_type = '0; MEM_ins_number = '0;
        dmem_ack = 0; dmem_rdata = '0;
    endtask

    task automatic run_access(input int n, input int ack_at, input logic [31:0] rd,
                              output int req_n, output int stall_n,
                              output int bub_n, output int we_n);
        req_n = 0; stall_n = 0; bub_n = 0; we_n = 0;
        for (int i = 0; i < n; i++) begin
            dmem_ack   = (i == ack_at);
            dmem_rdata = (i == ack_at) ? rd : 32'h0BAD_0BAD;
            #2;
            req_n   += int'(dmem_req);
            stall_n += int'(mem_stall);
            we_n    += int'(dmem_we);
            step();
            if (!wwreg && !wm2reg && walu == '0 && wrn == '0 && WB_ins_type == 4'h0)
                bub_n++;
        end
        dmem_ack = 0;
        dmem_rdata = '0;
    endtask

    int req_n, stall_n, bub_n, we_n;

    initial begin
        set_idle();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        check("rst wwreg",   32'(wwreg),    32'd0);
        check("rst mem_err", 32'(mem_err),  32'd0);
        #2 check("rst dmem_req", 32'(dmem_req), 32'd0);
        step();

        // Plain ALU op, with a stray ack that must be ignored
        mwreg = 1; maluout = 32'h0000_0010; mrdrt = 5'd5;
        MEM_ins_type = 4'h1; MEM_ins_number = 4'h1;
        dmem_ack = 1; dmem_rdata = 32'hFFFF_FFFF;
        #2;
        check("alu dmem_req",  32'(dmem_req),  32'd0);
        check("alu mem_stall", 32'(mem_stall), 32'd0);
        step();
        check("alu wwreg", 32'(wwreg), 32'd1);
        check("alu walu",  walu,       32'h10);
        check("alu wrn",   32'(wrn),   32'd5);
        check("alu wmo",   wmo,        32'd0);
        set_idle();
        step();

        // Load acked on the 4th request cycle
        mwreg = 1; mm2reg = 1; maluout = 32'h100; mrdrt = 5'd7;
        MEM_ins_type = 4'h2; MEM_ins_number = 4'h2;
        run_access(4, 3, 32'hDEAD_BEEF, req_n, stall_n, bub_n, we_n);
        check("load req cycles",   32'(req_n),   32'd4);
        check("load stall cycles", 32'(stall_n), 32'd3);
        check("load bubbles",      32'(bub_n),   32'd3);
        check("load wm2reg",       32'(wm2reg),  32'd1);
        check("load wmo",          wmo,          32'hDEAD_BEEF);
        check("load wrn",          32'(wrn),     32'd7);
        set_idle();
        step();

        // Zero-wait store
        mwmem = 1; mdata_b = 32'h1234; maluout = 32'h200;
        MEM_ins_type = 4'h3; MEM_ins_number = 4'h3;
        run_access(1, 0, 32'h0, req_n, stall_n, bub_n, we_n);
        check("store we",     32'(we_n),    32'd1);
        check("store stall",  32'(stall_n), 32'd0);
        check("store wwreg",  32'(wwreg),   32'd0);
        check("store walu",   walu,         32'h200);
        set_idle();
        step();

        // Branch taken / not taken, then suppressed by a stalling load
        mbranch = 1; mzero = 1; mpc = 32'h40;
        #2;
        check("br pcsrc",     32'(pcsrc), 32'd1);
        check("br branch_pc", branch_pc,  32'h40);
        step();
        mzero = 0;
        #2 check("br nz pcsrc", 32'(pcsrc), 32'd0);
        step();
        mzero = 1; mm2reg = 1; maluout = 32'h300;
        #2 check("br stall pcsrc", 32'(pcsrc), 32'd0);
        dmem_ack = 1; dmem_rdata = 32'h5;
        #1 check("br done pcsrc", 32'(pcsrc), 32'd1);
        step();
        set_idle();
        step();

        // Load with no ack: abandoned after TIMEOUT request cycles
        mwreg = 1; mm2reg = 1; maluout = 32'h400; mrdrt = 5'd9;
        MEM_ins_type = 4'h4; MEM_ins_number = 4'h4;
        run_access(TIMEOUT, -1, 32'h0, req_n, stall_n, bub_n, we_n);
        check("to req cycles",   32'(req_n),   32'd15);
        check("to stall cycles", 32'(stall_n), 32'd14);
        check("to bubbles",      32'(bub_n),   32'd15);
        check("to mem_err",      32'(mem_err), 32'd1);
        set_idle();
        #2 check("to back idle", 32'(dmem_req), 32'd0);
        step();
        step();
        check("to err sticky", 32'(mem_err), 32'd1);

        // Reset in the middle of WAIT, then a late ack
        mwreg = 1; mm2reg = 1; maluout = 32'h500; mrdrt = 5'd3;
        MEM_ins_type = 4'h5; MEM_ins_number = 4'h5;
        run_access(3, -1, 32'h0, req_n, stall_n, bub_n, we_n);
        rst_n = 0;
        #2;
        check("rstw dmem_req",  32'(dmem_req),  32'd0);
        check("rstw mem_stall", 32'(mem_stall), 32'd0);
        step();
        rst_n = 1;
        set_idle();
        dmem_ack = 1; dmem_rdata = 32'hCAFE_F00D;
        check("rstw wwreg",   32'(wwreg),   32'd0);
        check("rstw walu",    walu,         32'd0);
        check("rstw mem_err", 32'(mem_err), 32'd0);
        #2 check("late ack req", 32'(dmem_req), 32'd0);
        step();
        check("late ack wmo", wmo, 32'd0);
        set_idle();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
